// File: rtl/fetch_if.sv
// Fetch-stage bus: combinational ROM port, redirect input and the downstream
// valid/ready instruction slot, bundled for the fetch unit and its consumer.
interface fetch_if #(
    parameter int unsigned BW = 32,
    parameter int unsigned DW = 8
);
    logic [DW-1:0] rom_addr;
    logic [BW-1:0] rom_data;
    logic          redirect_valid;
    logic [DW-1:0] redirect_addr;
    logic          inst_valid;
    logic          inst_ready;
    logic [BW-1:0] inst_data;
    logic [DW-1:0] inst_pc;
    logic          halted;

    modport master (
        output rom_addr, inst_valid, inst_data, inst_pc, halted,
        input  rom_data, redirect_valid, redirect_addr, inst_ready
    );

    modport slave (
        input  rom_addr, inst_valid, inst_data, inst_pc, halted,
        output rom_data, redirect_valid, redirect_addr, inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a combinational ROM, registers
// the returned word with its address into a valid/ready slot; redirect flushes, halt word stops fetch.
module fetch_unit #(
    parameter int unsigned   BW        = 32,
    parameter int unsigned   DW        = 8,
    parameter logic [DW-1:0] RESET_PC  = '0,
    parameter logic [BW-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_pc;
    logic          r_inst_valid;
    logic [BW-1:0] r_inst_data;
    logic [DW-1:0] r_inst_pc;
    logic          r_halted;

    logic          w_slot_free;
    logic          w_is_halt;

    assign w_slot_free = !r_inst_valid || bus.inst_ready;
    assign w_is_halt   = (bus.rom_data == HALT_WORD);

    // Redirect outranks everything, including a halt word arriving the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
            r_halted     <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc         <= bus.redirect_addr;
            r_inst_valid <= 1'b0;
            r_state      <= ST_FETCH;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_slot_free) begin
                        r_inst_data  <= bus.rom_data;
                        r_inst_pc    <= r_pc;
                        r_inst_valid <= 1'b1;
                        if (w_is_halt) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc     <= r_pc + DW'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    // Let the halt word drain; nothing new is captured.
                    if (r_inst_valid && bus.inst_ready) begin
                        r_inst_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_FETCH;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr   = r_pc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst_data  = r_inst_data;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.halted     = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model in the bench, expected beats queued
// when stimulus is set up and popped on each downstream handshake.
module tb_fetch_unit;

    localparam int unsigned   BW   = 32;
    localparam int unsigned   DW   = 8;
    localparam logic [BW-1:0] HALT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic [BW-1:0] data;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0] rom [256];

    fetch_if #(.BW(BW), .DW(DW)) bus  ();
    fetch_if #(.BW(BW), .DW(DW)) bus2 ();

    assign bus.rom_data        = rom[bus.rom_addr];
    assign bus2.rom_data       = rom[bus2.rom_addr];
    assign bus2.inst_ready     = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_addr  = '0;

    fetch_unit #(.BW(BW), .DW(DW), .RESET_PC(8'h00), .HALT_WORD(HALT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_unit #(.BW(BW), .DW(DW), .RESET_PC(8'hFE), .HALT_WORD(HALT)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    beat_t q  [$];
    beat_t q2 [$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    en2   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_beat(input logic [DW-1:0] pc);
        q.push_back('{pc: pc, data: rom[pc]});
    endfunction

    function automatic void exp_beat2(input logic [DW-1:0] pc);
        q2.push_back('{pc: pc, data: rom[pc]});
    endfunction

    // One clock cycle: drive inputs, score any handshake, move to the next falling edge.
    task automatic cyc(input logic rdy, input logic rv, input logic [DW-1:0] ra);
        beat_t e;
        bus.inst_ready     = rdy;
        bus.redirect_valid = rv;
        bus.redirect_addr  = ra;
        #1;
        if (bus.inst_valid && rdy) begin
            n_cmp++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_beat observed pc=%0h expected no beat", bus.inst_pc);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("beat_pc", 64'(bus.inst_pc), 64'(e.pc));
                chk("beat_data", 64'(bus.inst_data), 64'(e.data));
            end
        end
        if (en2 && bus2.inst_valid) begin
            n_cmp++;
            assert (q2.size() != 0) else begin
                n_err++;
                $error("FAIL wrap_unexpected_beat observed pc=%0h expected no beat", bus2.inst_pc);
            end
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("wrap_pc", 64'(bus2.inst_pc), 64'(e.pc));
                chk("wrap_data", 64'(bus2.inst_data), 64'(e.data));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = BW'(i);
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.inst_valid), 64'(0));
        chk("rst_halted", 64'(bus.halted), 64'(0));
        chk("rst_data", 64'(bus.inst_data), 64'(0));
        chk("rst_pc", 64'(bus.inst_pc), 64'(0));
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'(0));
        chk("rst_rom_addr_wrap", 64'(bus2.rom_addr), 64'(8'hFE));

        // Release reset; first beat is visible one edge later.
        rst_n = 1'b1;
        exp_beat2(8'hFE); exp_beat2(8'hFF); exp_beat2(8'h00); exp_beat2(8'h01);
        en2 = 1'b1;
        chk("first_cycle_idle", 64'(bus.inst_valid), 64'(0));
        cyc(1'b1, 1'b0, '0);
        chk("first_valid", 64'(bus.inst_valid), 64'(1));
        for (int i = 0; i < 5; i++) exp_beat(DW'(i));
        repeat (4) cyc(1'b1, 1'b0, '0);
        en2 = 1'b0;
        chk("wrap_all_seen", 64'(q2.size()), 64'(0));
        cyc(1'b1, 1'b0, '0);

        // Stall with pc 5 in the slot.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, '0);
            chk("stall_valid", 64'(bus.inst_valid), 64'(1));
            chk("stall_pc", 64'(bus.inst_pc), 64'(5));
            chk("stall_data", 64'(bus.inst_data), 64'(5));
        end
        for (int i = 5; i <= 15; i++) exp_beat(DW'(i));
        repeat (10) cyc(1'b1, 1'b0, '0);
        chk("pre_redirect_rom_addr", 64'(bus.rom_addr), 64'(8'h10));
        chk("pre_redirect_pc", 64'(bus.inst_pc), 64'(8'h0F));

        // Redirect to 0x40 while presenting 0x10.
        cyc(1'b1, 1'b1, 8'h40);
        chk("redirect_bubble", 64'(bus.inst_valid), 64'(0));
        chk("redirect_rom_addr", 64'(bus.rom_addr), 64'(8'h40));
        exp_beat(8'h40); exp_beat(8'h41); exp_beat(8'h42);
        cyc(1'b1, 1'b0, '0);
        chk("redirect_target_valid", 64'(bus.inst_valid), 64'(1));
        chk("redirect_target_pc", 64'(bus.inst_pc), 64'(8'h40));
        repeat (2) cyc(1'b1, 1'b0, '0);

        // Halt word at address 3.
        rom[3] = HALT;
        cyc(1'b1, 1'b1, 8'h00);
        chk("q_drained_before_halt", 64'(q.size()), 64'(0));
        for (int i = 0; i < 4; i++) exp_beat(DW'(i));
        repeat (4) cyc(1'b1, 1'b0, '0);
        chk("halt_flag", 64'(bus.halted), 64'(1));
        chk("halt_word_pc", 64'(bus.inst_pc), 64'(3));
        chk("halt_word_data", 64'(bus.inst_data), 64'(HALT));
        repeat (4) cyc(1'b1, 1'b0, '0);
        chk("halted_no_valid", 64'(bus.inst_valid), 64'(0));
        chk("halted_still", 64'(bus.halted), 64'(1));
        chk("halted_pc_held", 64'(bus.rom_addr), 64'(3));
        chk("halt_all_seen", 64'(q.size()), 64'(0));

        // Redirect out of HALTED.
        rom[3] = 32'd3;
        cyc(1'b1, 1'b1, 8'h00);
        chk("unhalt_flag", 64'(bus.halted), 64'(0));
        chk("unhalt_valid", 64'(bus.inst_valid), 64'(0));
        chk("unhalt_rom_addr", 64'(bus.rom_addr), 64'(0));
        exp_beat(8'h00); exp_beat(8'h01); exp_beat(8'h02);
        repeat (4) cyc(1'b1, 1'b0, '0);

        // Halt word at the presented address loses to a simultaneous redirect.
        rom[4] = HALT;
        exp_beat(8'h03);
        cyc(1'b1, 1'b1, 8'h20);
        chk("redirect_beats_halt", 64'(bus.halted), 64'(0));
        chk("redirect_beats_halt_valid", 64'(bus.inst_valid), 64'(0));
        rom[4] = 32'd4;
        cyc(1'b1, 1'b0, '0);
        repeat (2) cyc(1'b0, 1'b0, '0);
        chk("pre_reset_valid", 64'(bus.inst_valid), 64'(1));
        chk("pre_reset_pc", 64'(bus.inst_pc), 64'(8'h20));
        chk("pre_reset_q_empty", 64'(q.size()), 64'(0));

        // Asynchronous reset mid-stall, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.inst_valid), 64'(0));
        chk("async_rst_halted", 64'(bus.halted), 64'(0));
        chk("async_rst_pc", 64'(bus.inst_pc), 64'(0));
        chk("async_rst_data", 64'(bus.inst_data), 64'(0));
        chk("async_rst_rom_addr", 64'(bus.rom_addr), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_beat(8'h00); exp_beat(8'h01); exp_beat(8'h02);
        repeat (4) cyc(1'b1, 1'b0, '0);
        chk("restart_all_seen", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
